// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : ID-stage per-register latency countdowns; raises RAW/WAW stalls.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic        rs1Use_i,
    input  logic        rs2Use_i,
    input  logic [4:0]  rd_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic        MulDiv_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        PCWrite_o,
    output logic        NoOp_o,
    output logic [31:0] pending_o,
    output logic [31:0] stallCount_o
);

    localparam logic [CNT_W-1:0] c_LOAD_LAT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] c_MUL_LAT  = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt_q [32];
    logic [CNT_W-1:0] w_cnt_d [32];
    logic [31:0]      r_stall_cnt_q;
    logic [31:0]      w_stall_cnt_d;
    logic [CNT_W-1:0] w_lat;
    logic             w_live;
    logic             w_raw;
    logic             w_waw;
    logic             w_stall;
    logic             w_issue;

    always_comb begin
        if (MulDiv_i) begin
            w_lat = c_MUL_LAT;
        end else if (MemRead_i) begin
            w_lat = c_LOAD_LAT;
        end else begin
            w_lat = '0;
        end
    end

    // Entry 0 is held at zero, so x0 never registers as a hazard.
    always_comb begin
        w_live  = valid_i && !flush_i;
        w_raw   = w_live && ((rs1Use_i && (rs1_i != 5'd0) && (r_cnt_q[rs1_i] != '0)) ||
                             (rs2Use_i && (rs2_i != 5'd0) && (r_cnt_q[rs2_i] != '0)));
        w_waw   = w_live && RegWrite_i && (rd_i != 5'd0) && (r_cnt_q[rd_i] > w_lat);
        w_stall = !rst_i && (w_raw || w_waw);
        w_issue = w_live && !w_stall;
    end

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            w_cnt_d[r] = (r_cnt_q[r] != '0) ? (r_cnt_q[r] - c_CNT_ONE) : '0;
        end
        if (w_issue && RegWrite_i && (rd_i != 5'd0)) begin
            w_cnt_d[rd_i] = w_lat;
        end
        w_cnt_d[0] = '0;
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_stall && (r_stall_cnt_q != 32'hFFFF_FFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt_q[r] <= '0;
            end
            r_stall_cnt_q <= 32'd0;
        end else begin
            r_cnt_q       <= w_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending_o[r] = (r_cnt_q[r] != '0);
        end
        pending_o[0] = 1'b0;
    end

    assign stall_o      = w_stall;
    assign PCWrite_o    = !w_stall;
    assign NoOp_o       = !rst_i && (w_stall || flush_i);
    assign stallCount_o = r_stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed stimulus with a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
    logic        rs1Use_i = 1'b0, rs2Use_i = 1'b0;
    logic        RegWrite_i = 1'b0, MemRead_i = 1'b0, MulDiv_i = 1'b0, flush_i = 1'b0;
    logic        stall_o, PCWrite_o, NoOp_o;
    logic [31:0] pending_o, stallCount_o;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1Use_i(rs1Use_i), .rs2Use_i(rs2Use_i),
        .rd_i(rd_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MulDiv_i(MulDiv_i),
        .flush_i(flush_i), .stall_o(stall_o), .PCWrite_o(PCWrite_o), .NoOp_o(NoOp_o),
        .pending_o(pending_o), .stallCount_o(stallCount_o)
    );

    always #5 clk = ~clk;

    // Model: avail[r] is the cycle number from which register r is readable.
    longint avail [32];
    longint now          = 0;
    longint stall_cycles = 0;
    longint sc_base      = 0;
    bit     model_valid  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint lat_of();
        if (MulDiv_i) return longint'(MUL_LAT);
        if (MemRead_i) return longint'(LOAD_LAT);
        return 0;
    endfunction

    function automatic bit model_stall();
        bit live = valid_i && !flush_i && !rst_i;
        bit raw  = (rs1Use_i && rs1_i != 0 && avail[rs1_i] > now) ||
                   (rs2Use_i && rs2_i != 0 && avail[rs2_i] > now);
        bit waw  = RegWrite_i && rd_i != 0 && (avail[rd_i] > now + lat_of());
        return live && (raw || waw);
    endfunction

    always @(posedge clk) begin
        now <= now + 1;
        if (rst_i) begin
            for (int r = 0; r < 32; r++) avail[r] <= 0;
            stall_cycles <= 0;
            model_valid  <= 1'b1;
        end else begin
            if (model_stall()) stall_cycles <= stall_cycles + 1;
            if (valid_i && !flush_i && !model_stall() && RegWrite_i && rd_i != 0)
                avail[rd_i] <= now + 1 + lat_of();
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            logic        es;
            logic [31:0] ep;
            longint      esc;
            es = model_stall();
            for (int r = 0; r < 32; r++) ep[r] = (r != 0) && (avail[r] > now);
            esc = sc_base + stall_cycles;
            if (esc > 64'hFFFF_FFFF) esc = 64'hFFFF_FFFF;
            chk("stall_o",      {31'b0, stall_o},   {31'b0, es});
            chk("PCWrite_o",    {31'b0, PCWrite_o}, {31'b0, !es});
            chk("NoOp_o",       {31'b0, NoOp_o},    {31'b0, !rst_i && (es || flush_i)});
            chk("pending_o",    pending_o,          ep);
            chk("stallCount_o", stallCount_o,       esc[31:0]);
        end
    end

    // Present one instruction, hold it while stalled, return stall cycles seen.
    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic md, output int stalls);
        bit done = 1'b0;
        valid_i = 1'b1; rs1_i = rs1; rs1Use_i = u1; rs2_i = rs2; rs2Use_i = u2;
        rd_i = rd; RegWrite_i = rw; MemRead_i = mr; MulDiv_i = md; flush_i = 1'b0;
        stalls = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!stall_o) done = 1'b1;
            else stalls++;
            @(posedge clk); #1;
        end
        if (!done) chk("issue_timeout", 32'd1, 32'd0);
        valid_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0; MulDiv_i = 1'b0;
        rs1Use_i = 1'b0; rs2Use_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0; flush_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        // Reset held with a would-be consumer present
        valid_i = 1'b1; rs1_i = 5'd5; rs1Use_i = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_pending", pending_o, 32'd0);
        chk("rst_count", stallCount_o, 32'd0);
        @(posedge clk); #1; rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1; idle(1);

        // Load-use
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, s);
        chk("lw_issue", s, 32'd0);
        issue(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, s);
        chk("load_use_stalls", s, 32'd1);
        @(negedge clk);
        chk("load_use_pend5", {31'b0, pending_o[5]}, 32'd0);
        chk("load_use_count", stallCount_o, 32'd1);
        @(posedge clk); #1; idle(4);

        // MUL dependency with 0, 1 and 3 independent instructions between
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, s);
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, s);
        chk("mul_use_0gap", s, 32'd3);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, s);
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, s);
        issue(5'd0, 1'b0, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, s);
        chk("mul_use_1gap", s, 32'd2);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, s);
        for (int i = 0; i < 3; i++) issue(5'd1, 1'b1, 5'd2, 1'b1, 5'(11 + i), 1'b1, 1'b0, 1'b0, s);
        issue(5'd3, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, s);
        chk("mul_use_3gap", s, 32'd0);
        idle(4);

        // WAW: ALU after MUL, then load after MUL
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, s);
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, s);
        chk("waw_alu_stalls", s, 32'd3);
        @(negedge clk);
        chk("waw_alu_pend4", {31'b0, pending_o[4]}, 32'd0);
        @(posedge clk); #1;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, s);
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, s);
        chk("waw_load_stalls", s, 32'd2);
        @(negedge clk);
        chk("waw_load_pend4_a", {31'b0, pending_o[4]}, 32'd1);
        @(negedge clk);
        chk("waw_load_pend4_b", {31'b0, pending_o[4]}, 32'd0);
        @(posedge clk); #1; idle(3);

        // Flush beats a would-be stall
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, s);
        valid_i = 1'b1; rs1_i = 5'd8; rs1Use_i = 1'b1; rs2_i = 5'd1; rs2Use_i = 1'b1;
        rd_i = 5'd9; RegWrite_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'b0, stall_o}, 32'd0);
        chk("flush_noop", {31'b0, NoOp_o}, 32'd1);
        @(posedge clk); #1; flush_i = 1'b0;
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, s);
        chk("post_flush_stalls", s, 32'd0);
        chk("flush_pend9", {31'b0, pending_o[9]}, 32'd0);
        idle(3);

        // x0 and unused sources
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, s);
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, s);
        chk("x0_stalls", s, 32'd0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, s);
        issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, s);
        chk("unused_src_stalls", s, 32'd0);
        idle(3);

        // Reset in the middle of a stall
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, s);
        valid_i = 1'b1; rs1_i = 5'd3; rs1Use_i = 1'b1; rd_i = 5'd10; RegWrite_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_stall", {31'b0, stall_o}, 32'd1);
        @(posedge clk); #1; rst_i = 1'b1;
        @(negedge clk);
        chk("in_rst_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1; rst_i = 1'b0;
        @(negedge clk);
        chk("after_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("after_rst_pending", pending_o, 32'd0);
        @(posedge clk); #1; idle(1);

        // Saturation of the stall counter from a preloaded value
        @(negedge clk); #1;
        dut.r_stall_cnt_q = 32'hFFFF_FFFD;
        sc_base = 64'hFFFF_FFFD - stall_cycles;
        @(posedge clk); #1;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, s);
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, s);
        chk("sat_stalls", s, 32'd3);
        @(negedge clk);
        chk("sat_count", stallCount_o, 32'hFFFF_FFFF);
        @(posedge clk); #1; idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
